i2s_tx_sched: RTL
=================

Name: i2s_tx_sched

Overview:
- Scheduler between two stereo sample producers and the i2s transmitter PHY.
- Source 0 is alerts/tones and has fixed priority; source 1 is stream playback.
- Grants the PHY to one source at a time, buffers samples in a FIFO, and starts the PHY only once the FIFO has pre-filled.
- Sequences a clean stop: drains the FIFO, releases phy_en, waits for PHY idle. Sits in vid_aud_tx beside the PHY.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=4); one entry = one stereo frame of 32 bits.
START_LEVEL, 4, FIFO level required before phy_en asserts (1..DEPTH).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_req  in  2  per-source ownership request; bit0 = source 0
s_valid  in  2  per-source sample valid
s_data0  in  32  source 0 sample; [31:16] chan1, [15:0] chan0
s_data1  in  32  source 1 sample; same layout
s_ready  out  2  per-source accept; push when s_valid[i] & s_ready[i]
grant  out  2  one-hot current owner; 0 when idle
phy_en  out  1  PHY run level
phy_busy  in  1  PHY running
phy_rd_valid  out  1  FIFO head is valid
phy_rd  in  1  PHY consumes head this cycle
phy_rd_data_chan0  out  16  head[15:0]
phy_rd_data_chan1  out  16  head[31:16]
fifo_level  out  log2(DEPTH)+1  entry count
underrun_cnt  out  16  saturating underrun counter

Behaviour:
- Reset values: grant=0, s_ready=0, phy_en=0, phy_rd_valid=0, FIFO empty, fifo_level=0, underrun_cnt=0, state IDLE. Reset is asynchronous and may occur in any state; it aborts immediately and the FIFO contents are discarded.
- States: IDLE, FILL, RUN, DRAIN, STOP.
- IDLE -> FILL when any s_req bit is set. Grant goes to source 0 if s_req[0], else source 1. Grant is registered and visible the cycle after entering FILL. Grant changes only in IDLE; no preemption.
- FILL: s_ready[owner] = !full; the other s_ready bit is 0.
  - -> RUN when fifo_level >= START_LEVEL.
  - -> RUN when s_req[owner] drops with level > 0.
  - -> IDLE when s_req[owner] drops with level == 0.
- RUN: phy_en = 1, and pushes continue. -> DRAIN when s_req[owner] drops. s_ready goes to 0 in the same cycle s_req drops.
- DRAIN: phy_en = 1, no pushes. -> STOP on the cycle the FIFO becomes empty.
- STOP: phy_en = 0. -> IDLE when phy_busy = 0. Grant clears on entry to IDLE.
- phy_rd_valid = !empty in RUN and DRAIN, 0 otherwise.
- Head data is combinational from the read pointer and stays stable until phy_rd. Pop occurs on phy_rd & !empty; phy_rd while empty is ignored.
- Simultaneous push and pop: level unchanged. Push is accepted when full only if a pop occurs in the same cycle (s_ready = !full | phy_rd). Pointers wrap modulo DEPTH.
- Underrun: in RUN, on each 1->0 transition of phy_rd_valid while s_req[owner] = 1, underrun_cnt increments by one, saturating at 0xFFFF. It is cleared only by reset.
- Data from a non-owner, or while s_req[owner] = 0, is never written.

Optional Feature:
I2S_SCHED_MUTE_EN: adds input port mute (1 bit).
- Defined: while mute = 1, phy_rd_data_chan0/1 read 0. Pops, handshake and the state machine are unchanged, so the stream keeps timing.
- Undefined: the port does not exist and data always comes from the FIFO head.

Test Plan:
1. Reset, assert s_req=2'b10, push 4 samples -> grant=2'b10 and phy_en rises the cycle after level reaches 4. With phy_rd pulses, data 0x0001_0002.. pops in order.
2. s_req=2'b11 from IDLE -> grant=2'b01. Source 1 s_ready stays 0 until source 0 finishes and the FSM returns to IDLE, then grant=2'b10.
3. Fill to DEPTH=8 with no phy_rd -> s_ready=0 and level=8. Push and phy_rd in the same cycle -> accepted and level stays 8.
4. In RUN, stop pushing and keep s_req=1 while phy_rd drains the FIFO -> underrun_cnt=1. Repeat 3 times -> 3.
5. Drop s_req after 2 pushes in FILL -> RUN, then DRAIN. phy_en falls after 2 pops, and IDLE is reached after phy_busy=0.
6. Assert rst mid-RUN with level=5 -> all outputs return to reset values asynchronously and level=0. With MUTE_EN defined and mute=1, data reads 0 while pops continue.

Source files
------------

// File: rtl/i2s_tx_sched_if.sv
// Bus bundle between the two sample producers, the scheduler and the i2s PHY.
// The mute input exists only when I2S_SCHED_MUTE_EN is defined.
interface i2s_tx_sched_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [1:0]       s_req;
   logic [1:0]       s_valid;
   logic [31:0]      s_data0;
   logic [31:0]      s_data1;
   logic [1:0]       s_ready;
   logic [1:0]       grant;
   logic             phy_en;
   logic             phy_busy;
   logic             phy_rd_valid;
   logic             phy_rd;
   logic [15:0]      phy_rd_data_chan0;
   logic [15:0]      phy_rd_data_chan1;
   logic [LVL_W-1:0] fifo_level;
   logic [15:0]      underrun_cnt;
`ifdef I2S_SCHED_MUTE_EN
   logic             mute;
`endif

   // Producers and PHY side
   modport master (
`ifdef I2S_SCHED_MUTE_EN
      output mute,
`endif
      output s_req, s_valid, s_data0, s_data1, phy_busy, phy_rd,
      input  s_ready, grant, phy_en, phy_rd_valid, phy_rd_data_chan0,
             phy_rd_data_chan1, fifo_level, underrun_cnt
   );

   // Scheduler side
   modport slave (
`ifdef I2S_SCHED_MUTE_EN
      input  mute,
`endif
      input  s_req, s_valid, s_data0, s_data1, phy_busy, phy_rd,
      output s_ready, grant, phy_en, phy_rd_valid, phy_rd_data_chan0,
             phy_rd_data_chan1, fifo_level, underrun_cnt
   );
endinterface

// File: rtl/i2s_tx_sched.sv
// Two-source i2s transmit scheduler: fixed-priority grant, pre-fill FIFO, clean stop.
// Optional build macro I2S_SCHED_MUTE_EN zeroes the head data while mute is high.
module i2s_tx_sched #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned START_LEVEL = 4
) (
   input  logic           clk,
   input  logic           rst,
   i2s_tx_sched_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, STOP} state_t;

   state_t           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             phy_en_q, phy_en_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic [15:0]      uf_cnt_q;
   logic [31:0]      mem_q [DEPTH];

   logic        owner, owner_req, full, empty, rd_valid;
   logic        accept_st, own_ready, push, pop, underrun;
   logic [31:0] own_data, head;

   // Ownership decode: bit1 of the one-hot grant selects source 1
   assign owner     = grant_q[1];
   assign owner_req = bus.s_req[owner];
   assign own_data  = owner ? bus.s_data1 : bus.s_data0;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign empty     = (level_q == '0);
   assign rd_valid  = ((state_q == RUN) || (state_q == DRAIN)) && !empty;
   assign pop       = bus.phy_rd && rd_valid;
   assign accept_st = ((state_q == FILL) || (state_q == RUN)) && owner_req;
   assign own_ready = accept_st && (!full || pop);
   assign push      = own_ready && bus.s_valid[owner];

   // Head about to empty while the owner still streams: PHY starved
   assign underrun  = (state_q == RUN) && owner_req && pop && !push &&
                      (level_q == LVL_W'(1));

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Next-state, grant and phy_en decode
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      phy_en_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.s_req != 2'b00) begin
               state_d = FILL;
               grant_d = bus.s_req[0] ? 2'b01 : 2'b10;
            end
         end
         FILL: begin
            if (!owner_req)                            state_d = empty ? IDLE : RUN;
            else if (level_q >= LVL_W'(START_LEVEL))   state_d = RUN;
         end
         RUN:     if (!owner_req)       state_d = DRAIN;
         DRAIN:   if (level_d == '0)    state_d = STOP;
         STOP:    if (!bus.phy_busy)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) grant_d = 2'b00;
      phy_en_d = (state_d == RUN) || (state_d == DRAIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q  <= 2'b00;
         phy_en_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         uf_cnt_q <= '0;
      end else begin
         grant_q  <= grant_d;
         phy_en_q <= phy_en_d;
         level_q  <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (underrun && (uf_cnt_q != 16'hFFFF)) uf_cnt_q <= uf_cnt_q + 16'd1;
      end
   end

   // Storage needs no reset: validity is tracked by the pointers and level
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= own_data;
   end

   assign head = mem_q[rd_ptr_q];

`ifdef I2S_SCHED_MUTE_EN
   assign bus.phy_rd_data_chan0 = bus.mute ? 16'h0000 : head[15:0];
   assign bus.phy_rd_data_chan1 = bus.mute ? 16'h0000 : head[31:16];
`else
   assign bus.phy_rd_data_chan0 = head[15:0];
   assign bus.phy_rd_data_chan1 = head[31:16];
`endif

   assign bus.s_ready      = own_ready ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign bus.grant        = grant_q;
   assign bus.phy_en       = phy_en_q;
   assign bus.phy_rd_valid = rd_valid;
   assign bus.fifo_level   = level_q;
   assign bus.underrun_cnt = uf_cnt_q;
endmodule
